// File: rtl/fsm.sv
// Moore detector for the serial bit pattern 1101, overlaps included.
// Raises a registered one-cycle flag while the pattern has just completed.
module fsm (
    input  logic clk,
    input  logic rst,
    input  logic inp,
    output logic out
);

    typedef enum logic [2:0] {
        S0    = 3'b000,
        S1    = 3'b001,
        S11   = 3'b010,
        S110  = 3'b011,
        S1101 = 3'b100
    } state_e;

    // Kept as a plain vector so the unused encodings stay representable.
    logic [2:0] state;
    logic [2:0] state_next;

    always_comb begin
        state_next = S0;
        case (state)
            S0:      state_next = inp ? S1    : S0;
            S1:      state_next = inp ? S11   : S0;
            S11:     state_next = inp ? S11   : S110;
            S110:    state_next = inp ? S1101 : S0;
            // The trailing 1 of a match also starts the next "11" prefix.
            S1101:   state_next = inp ? S11   : S0;
            default: state_next = S0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S0;
            out   <= 1'b0;
        end else begin
            state <= state_next;
            out   <= (state_next == S1101);
        end
    end

endmodule

// File: tb/tb_fsm.sv
// Directed self-checking bench for the 1101 serial pattern detector.
module tb_fsm;

    logic clk;
    logic rst;
    logic inp;
    logic out;

    int checks;
    int errors;

    fsm dut (
        .clk (clk),
        .rst (rst),
        .inp (inp),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bit on the falling edge, sample just after the rising edge.
    task automatic step(input string tag, input logic b, input logic exp_out);
        @(negedge clk);
        inp = b;
        @(posedge clk);
        #1;
        check(tag, {31'd0, out}, {31'd0, exp_out});
    endtask

    task automatic run_seq(input string tag, input logic [15:0] bits, input logic [15:0] exp,
                           input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step($sformatf("%s[%0d]", tag, n - 1 - i), bits[i], exp[i]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        inp    = 1'b0;
        rst    = 1'b0;

        // Reset held while inp toggles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inp = ~inp;
            @(posedge clk);
            #1;
            check("rst_out", {31'd0, out}, 32'd0);
            check("rst_state", {29'd0, dut.state}, 32'd0);
        end

        @(negedge clk);
        rst = 1'b1;
        inp = 1'b0;

        // Single detect followed by a 0.
        run_seq("single", 16'b1101_0, 16'b0001_0, 5);

        // Overlapping detections, then return to idle.
        run_seq("overlap", 16'b1101101_0, 16'b0001001_0, 8);

        // A run of ones never detects, then 0,0 back to idle.
        run_seq("ones", 16'b1111111111_00, 16'b0000000000_00, 12);

        // Near-miss stream, then 0 to idle.
        run_seq("near", 16'b1011001_0, 16'b0000000_0, 8);

        // Asynchronous reset mid-cycle while the flag is high.
        run_seq("pre_async", 16'b1101, 16'b0001, 4);
        #2;
        rst = 1'b0;
        #1;
        check("async_out", {31'd0, out}, 32'd0);
        check("async_state", {29'd0, dut.state}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        inp = 1'b0;

        // Reset mid-pattern discards the 110 prefix.
        run_seq("mid_pre", 16'b110, 16'b000, 3);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_state", {29'd0, dut.state}, 32'd0);
        run_seq("mid_post", 16'b1, 16'b0, 1);
        run_seq("mid_fresh", 16'b1101_0, 16'b0001_0, 5);
        run_seq("mid_idle", 16'b0, 16'b0, 1);

        // Illegal encoding recovers to S0 after one edge.
        @(negedge clk);
        inp = 1'b1;
        force dut.state = 3'b111;
        #1;
        release dut.state;
        @(posedge clk);
        #1;
        check("illegal_state", {29'd0, dut.state}, 32'd0);
        check("illegal_out", {31'd0, out}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm.md
# fsm

Moore-type serial pattern detector that watches a one-bit input stream and flags every occurrence of the bit sequence 1-1-0-1, overlaps included. It samples one input bit per clock and raises a registered one-cycle flag in the cycle after the final bit of the pattern is captured. It is a standalone control block for a single-bit serial stream and sits directly between a bit source and any logic that consumes the detect pulse.

## Interface
- No parameters; the pattern 1101 is fixed.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-low (rst=0 forces reset immediately, independent of clk).
- inp  input  1  serial data bit, sampled on each rising clk edge while rst=1.
- out  output 1  detect flag (Moore output); 1 only while the FSM is in state S1101.

## Operation
- States, 3-bit binary encoding:
  - S0=000: idle, no prefix matched.
  - S1=001: "1" seen.
  - S11=010: "11" seen.
  - S110=011: "110" seen.
  - S1101=100: full pattern seen.
- Transitions, evaluated at the rising edge with inp, listed as state: inp=0 -> next, inp=1 -> next:
  - S0: 0 -> S0, 1 -> S1.
  - S1: 0 -> S0, 1 -> S11.
  - S11: 0 -> S110, 1 -> S11.
  - S110: 0 -> S0, 1 -> S1101.
  - S1101: 0 -> S0, 1 -> S11. The overlap keeps the trailing "1", so 1101 followed by 1 counts as "11".
- Output depends on state only: out=1 in S1101, out=0 in every other state. inp never affects out combinationally.
- out is held in a flop loaded with (next_state==S1101) on the same edge as the state register, so it is glitch-free and aligned with the state.
- Illegal encodings 101, 110 and 111 go to S0 on the next edge with out=0. No lock-up is allowed.

## Timing
- Reset:
  - While rst=0, state=S0 and out=0, asynchronously, within the same delta and without waiting for a clock edge.
  - Reset mid-sequence discards all partial match history.
- Release: the first rising edge with rst=1 samples inp as the first bit of a new sequence. Deassertion is taken as synchronised externally.
- Latency: with the 4th pattern bit (1) sampled at edge N, out=1 from edge N until edge N+1. That is exactly one cycle per detection unless the pattern repeats again.
- Back-to-back: for stream 1101101, out pulses after bit 4 and after bit 7. The minimum spacing between pulses is 3 cycles.
- A continuous run of 1s holds the state in S11 with out=0 indefinitely.
- Input setup and hold are relative to the rising clk edge only. inp changes between edges have no effect.

## Test plan
- Reset: hold rst=0 for 3 cycles while toggling inp -> out=0 and state=S0 throughout; drop rst low mid-cycle -> out=0 before the next edge.
- Single detect: after release, drive inp=1,1,0,1 on consecutive edges -> out=0,0,0,1, then out=0 on the following edge when inp=0.
- Overlap: inp=1,1,0,1,1,0,1 -> out=1 after the 4th and the 7th bit only, exactly 2 pulses.
- Near-misses: inp held 1 for 10 cycles -> out stays 0; inp=1,0,1,1,0,0,1 -> out never 1.
- Reset mid-pattern: inp=1,1,0, then rst=0 for one cycle, then inp=1 -> no detect; a fresh 1,1,0,1 afterwards -> out=1.
- Illegal state: force the state register to 111 and clock with inp=1 -> state=S0 and out=0 after one edge.
